ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_pkg.sv | 53 +++++
 rtl/ahb_rr_picker.sv | 44 ++++
 rtl/ahb_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ahb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared types and helpers for the AHB bus arbiter.
//   htrans_t    : AHB transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_t    : AHB burst type encoding
//   arb_state_t : arbiter control states (ARB, BURST, LOCKED)
//   burst_beats : number of beats of a fixed-length burst, 1 for SINGLE/INCR
//   is_fixed_burst : true for the 4/8/16-beat burst types
// -----------------------------------------------------------------------------
package ahb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  function automatic logic [4:0] burst_beats(input hburst_t b);
    logic [4:0] beats;
    case (b)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

  function automatic logic is_fixed_burst(input hburst_t b);
    return (burst_beats(b) > 5'd1);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// -----------------------------------------------------------------------------
// ahb_rr_picker
// Combinational round-robin search. Scans the request vector starting at
// (ptr + 1) mod NUM_MASTERS and wrapping around, so the master at ptr itself
// is considered last.
// Ports:
//   req    in  NUM_MASTERS  request vector
//   ptr    in  IDX_W        index of the previous winner
//   winner out NUM_MASTERS  one-hot winner (all zero when no request)
//   valid  out 1            at least one request present
// -----------------------------------------------------------------------------
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic                   valid
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    pos    = 0;
    idx    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_MASTERS) begin
        pos = pos - NUM_MASTERS;
      end
      idx = IDX_W'(pos);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter
// AHB bus arbiter: round-robin grant among requesting masters, with grant
// hold for fixed-length bursts, undefined-length INCR continuation and
// locked transfer sequences.
// Ports:
//   HCLK       in  1            clock, all state changes on rising edge
//   HRST       in  1            synchronous active-high reset
//   HBUSREQ    in  NUM_MASTERS  per-master bus request
//   HLOCK      in  NUM_MASTERS  per-master locked-transfer request
//   HTRANS     in  2            transfer type of the address-phase master
//   HBURST     in  3            burst type of the address-phase master
//   HREADY     in  1            shared ready, transfers accepted when 1
//   HGRANT     out NUM_MASTERS  one-hot registered grant
//   HMASTER    out IDX_W        index of the address-phase owner
//   HMASTLOCK  out 1            current address-phase transfer is locked
// The "owner" used for continuation and lock release is the current grant
// holder, which is also the master driving HTRANS/HBURST while a grant is
// held across a burst or locked sequence.
// -----------------------------------------------------------------------------
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRST,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [IDX_W-1:0]       HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  arb_state_t             state_q,     state_d;
  logic [NUM_MASTERS-1:0] grant_q,     grant_d;
  logic [IDX_W-1:0]       ptr_q,       ptr_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [IDX_W-1:0]       hmaster_q,   hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  htrans_t                htrans;
  hburst_t                hburst;
  logic [IDX_W-1:0]       owner_idx;
  logic [NUM_MASTERS-1:0] rr_winner;
  logic                   rr_valid;
  logic [IDX_W-1:0]       rr_idx;

  logic                   keep_owner;
  logic [NUM_MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       arb_ptr;
  logic                   arb_lock;
  logic                   rearb;

  assign htrans    = htrans_t'(HTRANS);
  assign hburst    = hburst_t'(HBURST);
  assign owner_idx = onehot_to_idx(grant_q);
  assign rr_idx    = onehot_to_idx(rr_winner);

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_picker (
    .req    (HBUSREQ),
    .ptr    (ptr_q),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // Arbitration decision, used whenever the grant is free to move. An owner
  // still streaming an undefined-length INCR keeps the bus; otherwise the
  // round-robin winner takes it, and an idle bus parks on DEFAULT_MASTER
  // without disturbing the rotation pointer. Lock carries no priority: it
  // only matters after the winner has been chosen.
  always_comb begin
    keep_owner = HBUSREQ[owner_idx] && (hburst == HBURST_INCR) &&
                 (htrans != HTRANS_IDLE);
    arb_grant  = DEF_GRANT;
    arb_idx    = DEF_IDX;
    arb_ptr    = ptr_q;
    if (keep_owner) begin
      arb_grant = grant_q;
      arb_idx   = owner_idx;
      arb_ptr   = owner_idx;
    end else if (rr_valid) begin
      arb_grant = rr_winner;
      arb_idx   = rr_idx;
      arb_ptr   = rr_idx;
    end
    arb_lock = HLOCK[arb_idx];
  end

  // Next-state logic. Nothing moves on wait states; on an accepted transfer
  // the address-phase registers follow the grant, and the FSM decides
  // whether the grant holds or is re-arbitrated on this same edge.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    rearb       = 1'b0;

    if (HREADY) begin
      hmaster_d   = owner_idx;
      hmastlock_d = HLOCK[owner_idx];

      case (state_q)
        ST_ARB: begin
          // The first beat of a fixed burst is the NONSEQ itself, so the
          // counter tracks the SEQ beats still to come.
          if ((htrans == HTRANS_NONSEQ) && is_fixed_burst(hburst)) begin
            state_d = ST_BURST;
            cnt_d   = CNT_W'(burst_beats(hburst) - 5'd1);
          end else begin
            rearb = 1'b1;
          end
        end

        ST_BURST: begin
          case (htrans)
            HTRANS_SEQ: begin
              if (cnt_q <= CNT_W'(1)) begin
                cnt_d = '0;
                rearb = 1'b1;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            HTRANS_IDLE, HTRANS_NONSEQ: begin
              cnt_d = '0;
              rearb = 1'b1;
            end
            default: ; // BUSY holds the beat count
          endcase
        end

        ST_LOCKED: begin
          if (!HLOCK[owner_idx] &&
              ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ))) begin
            rearb = 1'b1;
          end
        end

        default: state_d = ST_ARB;
      endcase

      if (rearb) begin
        grant_d = arb_grant;
        ptr_d   = arb_ptr;
        state_d = arb_lock ? ST_LOCKED : ST_ARB;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state_q     <= ST_ARB;
      grant_q     <= DEF_GRANT;
      ptr_q       <= DEF_IDX;
      cnt_q       <= '0;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed scenarios followed by randomized traffic, each accepted edge
// compared against a transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  ahb_arbiter #(
    .NUM_MASTERS    (N),
    .DEFAULT_MASTER (DEF)
  ) dut (
    .HCLK      (clk),
    .HRST      (rst),
    .HBUSREQ   (hbusreq),
    .HLOCK     (hlock),
    .HTRANS    (htrans),
    .HBURST    (hburst),
    .HREADY    (hready),
    .HGRANT    (hgrant),
    .HMASTER   (hmaster),
    .HMASTLOCK (hmastlock)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the bus, how many SEQ beats a fixed burst
  // still owes, and whether the holder is in a locked sequence.
  int m_owner    = DEF;
  int m_ptr      = DEF;
  int m_hmaster  = DEF;
  bit m_mastlock = 1'b0;
  bit m_in_burst = 1'b0;
  bit m_in_lock  = 1'b0;
  int m_seq_left = 0;

  function automatic int beats_of(input logic [2:0] b);
    if (b == 3'd2 || b == 3'd3) return 4;
    if (b == 3'd4 || b == 3'd5) return 8;
    if (b == 3'd6 || b == 3'd7) return 16;
    return 1;
  endfunction

  function automatic bit bit_at(input logic [3:0] v, input int i);
    return v[2'(i)];
  endfunction

  task automatic model_edge();
    int winner;
    bit rearb;
    int new_hm;
    bit new_ml;
    if (rst) begin
      m_owner = DEF; m_ptr = DEF; m_hmaster = DEF; m_mastlock = 1'b0;
      m_in_burst = 1'b0; m_in_lock = 1'b0; m_seq_left = 0;
      return;
    end
    if (!hready) return;
    new_hm = m_owner;
    new_ml = bit_at(hlock, m_owner);
    rearb  = 1'b0;
    if (m_in_burst) begin
      if (htrans == 2'd3) begin
        m_seq_left = m_seq_left - 1;
        if (m_seq_left <= 0) begin m_in_burst = 1'b0; rearb = 1'b1; end
      end else if (htrans == 2'd0 || htrans == 2'd2) begin
        m_in_burst = 1'b0; m_seq_left = 0; rearb = 1'b1;
      end
    end else if (m_in_lock) begin
      if (!bit_at(hlock, m_owner) && (htrans == 2'd0 || htrans == 2'd2)) begin
        m_in_lock = 1'b0; rearb = 1'b1;
      end
    end else if (htrans == 2'd2 && beats_of(hburst) > 1) begin
      m_in_burst = 1'b1;
      m_seq_left = beats_of(hburst) - 1;
    end else begin
      rearb = 1'b1;
    end
    if (rearb) begin
      if (bit_at(hbusreq, m_owner) && hburst == 3'd1 && htrans != 2'd0) begin
        winner = m_owner;
        m_ptr  = m_owner;
      end else if (hbusreq != 4'd0) begin
        winner = -1;
        for (int k = 1; k <= N; k++) begin
          if (winner < 0 && bit_at(hbusreq, (m_ptr + k) % N)) winner = (m_ptr + k) % N;
        end
        m_ptr = winner;
      end else begin
        winner = DEF;
      end
      m_owner   = winner;
      m_in_lock = bit_at(hlock, winner);
    end
    m_hmaster  = new_hm;
    m_mastlock = new_ml;
  endtask

  task automatic check(input string tag);
    logic [3:0] exp_g;
    exp_g = 4'(1) << m_owner;
    n_cmp++;
    assert (hgrant === exp_g) else begin
      n_err++; $error("FAIL %s grant: got %b want %b", tag, hgrant, exp_g);
    end
    n_cmp++;
    assert (hmaster === 2'(m_hmaster)) else begin
      n_err++; $error("FAIL %s hmaster: got %0d want %0d", tag, hmaster, m_hmaster);
    end
    n_cmp++;
    assert (hmastlock === m_mastlock) else begin
      n_err++; $error("FAIL %s hmastlock: got %b want %b", tag, hmastlock, m_mastlock);
    end
    n_cmp++;
    assert ($onehot(hgrant) === 1'b1) else begin
      n_err++; $error("FAIL %s onehot: got %b want one-hot", tag, hgrant);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g,
                            input logic [1:0] hm, input logic ml);
    n_cmp++;
    assert (hgrant === g) else begin
      n_err++; $error("FAIL %s grant: got %b want %b", tag, hgrant, g);
    end
    n_cmp++;
    assert (hmaster === hm) else begin
      n_err++; $error("FAIL %s hmaster: got %0d want %0d", tag, hmaster, hm);
    end
    n_cmp++;
    assert (hmastlock === ml) else begin
      n_err++; $error("FAIL %s hmastlock: got %b want %b", tag, hmastlock, ml);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] req, input logic [3:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    rst = r; hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    drive(1'b1, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("reset");
    tick("reset");
    expect_out("reset_vals", 4'b0001, 2'd0, 1'b0);

    // Rotation with all masters requesting SINGLE transfers
    drive(1'b0, 4'hF, 4'h0, 2'd2, 3'd0, 1'b1);
    tick("rot"); expect_out("rot1", 4'b0010, 2'd0, 1'b0);
    tick("rot"); expect_out("rot2", 4'b0100, 2'd1, 1'b0);
    tick("rot"); expect_out("rot3", 4'b1000, 2'd2, 1'b0);
    tick("rot"); expect_out("rot0", 4'b0001, 2'd3, 1'b0);

    // M1 INCR4 while M2 requests
    drive(1'b0, 4'b0010, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("m1_get"); tick("m1_get");
    expect_out("m1_owner", 4'b0010, 2'd1, 1'b0);
    drive(1'b0, 4'b0110, 4'h0, 2'd2, 3'd3, 1'b1);
    tick("incr4_b1"); expect_out("incr4_b1", 4'b0010, 2'd1, 1'b0);
    drive(1'b0, 4'b0110, 4'h0, 2'd3, 3'd3, 1'b1);
    tick("incr4_b2"); expect_out("incr4_b2", 4'b0010, 2'd1, 1'b0);
    tick("incr4_b3"); expect_out("incr4_b3", 4'b0010, 2'd1, 1'b0);
    tick("incr4_b4"); expect_out("incr4_b4", 4'b0100, 2'd1, 1'b0);
    drive(1'b0, 4'b0100, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("incr4_hm"); expect_out("incr4_hm", 4'b0100, 2'd2, 1'b0);

    // M3 WRAP8 with three wait states after the third beat
    drive(1'b0, 4'b1000, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("m3_get"); tick("m3_get");
    expect_out("m3_owner", 4'b1000, 2'd3, 1'b0);
    drive(1'b0, 4'b1001, 4'h0, 2'd2, 3'd4, 1'b1);
    tick("wrap8_b1");
    drive(1'b0, 4'b1001, 4'h0, 2'd3, 3'd4, 1'b1);
    tick("wrap8_b2"); tick("wrap8_b3");
    drive(1'b0, 4'b1001, 4'h0, 2'd3, 3'd4, 1'b0);
    for (int w = 0; w < 3; w++) begin
      tick("wrap8_wait"); expect_out("wrap8_wait", 4'b1000, 2'd3, 1'b0);
    end
    drive(1'b0, 4'b1001, 4'h0, 2'd3, 3'd4, 1'b1);
    for (int b = 4; b < 8; b++) begin
      tick("wrap8_mid"); expect_out("wrap8_mid", 4'b1000, 2'd3, 1'b0);
    end
    tick("wrap8_b8"); expect_out("wrap8_end", 4'b0001, 2'd3, 1'b0);

    // M0 locked INCR while M1 requests
    drive(1'b0, 4'b0011, 4'b0001, 2'd2, 3'd1, 1'b1);
    tick("lock_in"); expect_out("lock_in", 4'b0001, 2'd0, 1'b1);
    drive(1'b0, 4'b0011, 4'b0001, 2'd3, 3'd1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      tick("lock_hold"); expect_out("lock_hold", 4'b0001, 2'd0, 1'b1);
    end
    drive(1'b0, 4'b0011, 4'b0001, 2'd0, 3'd0, 1'b1);
    tick("lock_idle"); expect_out("lock_idle", 4'b0001, 2'd0, 1'b1);
    drive(1'b0, 4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1);
    tick("lock_out"); expect_out("lock_out", 4'b0010, 2'd0, 1'b0);

    // Parking on the default master, then reset inside a locked INCR16
    drive(1'b0, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("park"); tick("park");
    expect_out("park", 4'b0001, 2'd0, 1'b0);
    drive(1'b0, 4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1);
    tick("m2_lock");
    drive(1'b0, 4'b0100, 4'b0100, 2'd2, 3'd7, 1'b1);
    tick("incr16_b1"); expect_out("incr16_b1", 4'b0100, 2'd2, 1'b1);
    drive(1'b0, 4'b0100, 4'b0100, 2'd3, 3'd7, 1'b1);
    tick("incr16_seq"); tick("incr16_seq"); tick("incr16_seq");
    drive(1'b1, 4'b0100, 4'b0100, 2'd3, 3'd7, 1'b1);
    tick("mid_rst"); expect_out("mid_rst", 4'b0001, 2'd0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("post_rst"); expect_out("post_rst", 4'b0001, 2'd0, 1'b0);

    // M2 cuts INCR8 short with NONSEQ after 3 beats while M3 requests
    drive(1'b0, 4'b0100, 4'h0, 2'd0, 3'd0, 1'b1);
    tick("m2_get"); tick("m2_get");
    drive(1'b0, 4'b1100, 4'h0, 2'd2, 3'd5, 1'b1);
    tick("incr8_b1");
    drive(1'b0, 4'b1100, 4'h0, 2'd3, 3'd5, 1'b1);
    tick("incr8_b2"); tick("incr8_b3");
    expect_out("incr8_b3", 4'b0100, 2'd2, 1'b0);
    drive(1'b0, 4'b1100, 4'h0, 2'd2, 3'd0, 1'b1);
    tick("incr8_term"); expect_out("incr8_term", 4'b1000, 2'd2, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] req;
      req = 4'($urandom);
      drive(($urandom_range(0, 99) == 0),
            req,
            req & 4'($urandom) & 4'($urandom) & 4'($urandom),
            2'($urandom),
            3'($urandom),
            ($urandom_range(0, 3) != 0));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
